bus_mtimer: RTL

- Memory-mapped RISC-V machine timer that sits on the core's system bus as a slave, beside main memory.
- Holds a 64-bit mtime counter, driven by a programmable prescaler, and a 64-bit mtimecmp compare register.
- Raises a level machine-timer interrupt toward rv_core.
- The system top binds its discrete bus ports to the shared bus interface.

---
 rtl/bus_mtimer_pkg.sv | 18 +
 rtl/mtimer_prescaler.sv | 16 +
 rtl/bus_mtimer.sv | 84 ++++++++
 3 files changed

// File: rtl/bus_mtimer_pkg.sv
// bus_mtimer_pkg: register offsets, ctrl fields, bus FSM states and mtime type shared by bus_mtimer
package bus_mtimer_pkg;
  localparam logic [4:0] MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] CTRL        = 5'h10;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_PS_LSB = 8;
  localparam int CTRL_PS_MSB = 15;
  typedef enum logic {IDLE, ACK} state_t;
  typedef logic [63:0] mtime_t;
  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? data[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler: divides clk by (prescale+1) while enabled, producing a one-cycle tick
// Ports: clk, rst_n (sync active-low); enable, prescale[7:0], clear in; tick out.
module mtimer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] prescale,
  input  logic       clear,
  output logic       tick
);
  logic [7:0] cnt;
  assign tick = enable && cnt == prescale;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= (!enable || clear || tick) ? '0 : cnt + 8'd1;
endmodule

// File: rtl/bus_mtimer.sv
// bus_mtimer: memory-mapped RISC-V machine timer (mtime, mtimecmp, ctrl) with level irq
// Ports: clk, rst_n (sync active-low); addr/rd/wr/wdata/be bus request; sel decode hit;
//        rdata/ack one-cycle registered response; irq machine-timer interrupt.
// Option: BUS_MTIMER_SNAPSHOT_EN shadows mtime_hi on mtime_lo reads for atomic lo-then-hi reads.
module bus_mtimer
  import bus_mtimer_pkg::*;
#(
  parameter logic [31:0] BaseAddress   = 32'h0001_0000,
  parameter int unsigned WindowBytes   = 32,
  parameter logic [7:0]  ResetPrescale = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        irq
);
  localparam logic [31:0] Mask = ~(WindowBytes - 32'd1);
  state_t state, state_next;
  mtime_t mtime, mtimecmp;
  logic enable, tick, go, do_wr, do_rd, wr_lo, wr_hi, wr_ps;
  logic [7:0] prescale;
  logic [4:0] off;
  logic [31:0] lo_next, hi_next, hi_rd, rval;
  assign sel   = (rd | wr) && ((addr & Mask) == BaseAddress);
  assign off   = {addr[4:2], 2'b00};
  assign go    = state == IDLE && sel;
  assign do_wr = go && wr;
  assign do_rd = go && !wr;
  assign wr_lo = do_wr && off == MTIME_LO;
  assign wr_hi = do_wr && off == MTIME_HI;
  assign wr_ps = do_wr && off == CTRL && be[1];
  assign ack   = state == ACK;
  always_comb state_next = go ? ACK : IDLE;
  mtimer_prescaler u_ps (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prescale(prescale),
    .clear(wr_ps | wr_lo | wr_hi), .tick(tick)
  );
  // A bus write to either mtime half drops the tick for that half; the other half
  // still advances on its own, with no carry crossing between halves that cycle.
  assign lo_next = wr_lo ? merge_be(mtime[31:0], wdata, be) : mtime[31:0] + {31'b0, tick};
  assign hi_next = wr_hi ? merge_be(mtime[63:32], wdata, be)
                         : mtime[63:32] + {31'b0, tick && !wr_lo && &mtime[31:0]};
`ifdef BUS_MTIMER_SNAPSHOT_EN
  logic [31:0] shadow;
  always_ff @(posedge clk)
    if (!rst_n) shadow <= '0;
    else if (wr_hi) shadow <= hi_next;
    else if (do_rd && off == MTIME_LO) shadow <= mtime[63:32];
  assign hi_rd = shadow;
`else
  assign hi_rd = mtime[63:32];
`endif
  assign rval = off == MTIME_LO    ? mtime[31:0] :
                off == MTIME_HI    ? hi_rd :
                off == MTIMECMP_LO ? mtimecmp[31:0] :
                off == MTIMECMP_HI ? mtimecmp[63:32] :
                off == CTRL        ? {16'h0, prescale, 7'h0, enable} : '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state    <= IDLE;
      mtime    <= '0;
      mtimecmp <= '1;
      enable   <= 1'b0;
      prescale <= ResetPrescale;
      rdata    <= '0;
      irq      <= 1'b0;
    end else begin
      state <= state_next;
      mtime <= {hi_next, lo_next};
      if (do_wr && off == MTIMECMP_LO) mtimecmp[31:0] <= merge_be(mtimecmp[31:0], wdata, be);
      if (do_wr && off == MTIMECMP_HI) mtimecmp[63:32] <= merge_be(mtimecmp[63:32], wdata, be);
      if (do_wr && off == CTRL && be[0]) enable <= wdata[CTRL_EN];
      if (wr_ps) prescale <= wdata[CTRL_PS_MSB:CTRL_PS_LSB];
      rdata <= do_rd ? rval : '0;
      irq   <= mtime >= mtimecmp;
    end
endmodule
